// File: rtl/mult_div_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with HI/LO registers.
// Define MDU_SIGNED_EN to let op[1] select signed MULT/DIV; otherwise op[1] is ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MDU_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] acc_hi, acc_lo, operand;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r, zero_flag;

    logic             is_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod_final;

    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_fit;
    logic [WIDTH-1:0] rem_next, quo_next, rem_final, quo_final;

    // Signed operands are reduced to magnitudes so a single unsigned core serves both modes.
    assign is_signed = op[1] & SIGNED_EN;
    assign rs_neg    = is_signed & rs_val[WIDTH-1];
    assign rt_neg    = is_signed & rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;

    // Multiply: {acc_hi, acc_lo} is the product register, multiplier shifts out of acc_lo.
    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    assign mul_next   = {mul_sum, acc_lo[WIDTH-1:1]};
    assign prod_final = neg_q ? -mul_next : mul_next;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, operand};
    assign div_fit   = ~div_diff[WIDTH];
    assign rem_next  = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {acc_lo[WIDTH-2:0], div_fit};
    assign rem_final = neg_r ? -rem_next : rem_next;
    assign quo_final = neg_q ? -quo_next : quo_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op[0])            state_next = MUL;
                    else if (rt_val == '0) state_next = FINISH;
                    else                   state_next = DIV;
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (count == LAST) state_next = FINISH;
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                div_zero   = zero_flag;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // hi/lo only change on completion, on an idle MTHI/MTLO, or on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand   <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_flag <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= '0;
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                        acc_hi <= '0;
                        if (!op[0]) begin
                            acc_lo  <= rt_mag;
                            operand <= rs_mag;
                        end else if (rt_val == '0) begin
                            zero_flag <= 1'b1;
                            hi        <= rs_val;
                            lo        <= '1;
                        end else begin
                            acc_lo  <= rs_mag;
                            operand <= rt_mag;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MUL: begin
                    {acc_hi, acc_lo} <= mul_next;
                    count            <= count + 1'b1;
                    if (count == LAST) {hi, lo} <= prod_final;
                end
                DIV: begin
                    acc_hi <= rem_next;
                    acc_lo <= quo_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        hi <= rem_final;
                        lo <= quo_final;
                    end
                end
                FINISH: zero_flag <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// against an arithmetic reference model (honours MDU_SIGNED_EN like the design).
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_hi, model_lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Result of one operation computed with plain 64-bit arithmetic.
    function automatic void refModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        bit     sgn;
        longint sa, sb, q, r;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = o[1];
`endif
        dz = 1'b0;
        if (o[0] && b == 0) begin
            dz = 1'b1;
            h  = a;
            l  = '1;
            return;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        if (!o[0]) begin
            q = sa * sb;
            h = q[63:32];
            l = q[31:0];
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    // mode 0: plain; 1: start and hi_we pulsed mid-operation; 2: hi_we/lo_we with start
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int mode);
        logic [W-1:0] eh, el;
        logic         edz;
        int           lat, exp_lat;
        bit           busy_ok, hold_ok;
        refModel(o, a, b, eh, el, edz);
        exp_lat = edz ? 1 : W + 1;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (mode == 2) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        op     = 2'($urandom);
        lat     = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== model_hi || lo !== model_lo) hold_ok = 1'b0;
            if (mode == 1 && lat == 4) begin
                start  = 1'b1;
                op     = 2'b01;
                rt_val = '0;
            end
            if (mode == 1 && lat == 5) begin
                start = 1'b0;
                hi_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            if (mode == 1 && lat == 6) hi_we = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        checkOutput({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
        checkOutput({tag, " busy_at_done"}, 64'(busy), 64'd1);
        checkOutput({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        checkOutput({tag, " hi"}, 64'(hi), 64'(eh));
        checkOutput({tag, " lo"}, 64'(lo), 64'(el));
        model_hi = eh;
        model_lo = el;
        @(posedge clk);
        #1;
        checkOutput({tag, " done_after"}, 64'(done), 64'd0);
        checkOutput({tag, " busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic writeHiLo(input logic hw, input logic lw, input logic [W-1:0] d);
        @(negedge clk);
        hi_we = hw;
        lo_we = lw;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
        checkOutput("mtx hi", 64'(hi), 64'(model_hi));
        checkOutput("mtx lo", 64'(lo), 64'(model_lo));
    endtask

    initial begin
        bit seen_done;
        rst    = 1'b1;
        start  = 1'b0;
        op     = '0;
        rs_val = '0;
        rt_val = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        model_hi = '0;
        model_lo = '0;
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset div_zero", 64'(div_zero), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        checkOutput("multu max lit hi", 64'(hi), 64'hFFFF_FFFE);
        checkOutput("multu max lit lo", 64'(lo), 64'h0000_0001);

        applyStimulus("divu 100/7", 2'b01, 32'd100, 32'd7, 0);
        checkOutput("divu lit lo", 64'(lo), 64'd14);
        checkOutput("divu lit hi", 64'(hi), 64'd2);

        applyStimulus("divu by zero", 2'b01, 32'h1234, 32'd0, 0);
        checkOutput("div0 lit hi", 64'(hi), 64'h1234);
        checkOutput("div0 lit lo", 64'(lo), 64'hFFFF_FFFF);

        applyStimulus("multu disturbed", 2'b00, 32'h0001_2345, 32'h0006_789A, 1);
        writeHiLo(1'b1, 1'b0, 32'hA5A5_A5A5);
        checkOutput("mthi lit", 64'(hi), 64'hA5A5_A5A5);
        writeHiLo(1'b0, 1'b1, 32'h0BAD_F00D);
        writeHiLo(1'b1, 1'b1, 32'h5A5A_1234);

        applyStimulus("start beats we", 2'b00, 32'd6, 32'd7, 2);

        // Reset in the middle of a divide must abort it with no completion pulse.
        writeHiLo(1'b1, 1'b1, 32'h5A5A_1234);
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort hi", 64'(hi), 64'd0);
        checkOutput("abort lo", 64'(lo), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checkOutput("abort no done", 64'(seen_done), 64'd0);
        applyStimulus("multu 3*5", 2'b00, 32'd3, 32'd5, 0);
        checkOutput("multu 3*5 lit lo", 64'(lo), 64'd15);
        checkOutput("multu 3*5 lit hi", 64'(hi), 64'd0);

        applyStimulus("mult -3*5", 2'b10, 32'hFFFF_FFFD, 32'd5, 0);
        applyStimulus("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
`ifdef MDU_SIGNED_EN
        checkOutput("div -7/2 lit lo", 64'(lo), 64'hFFFF_FFFD);
        checkOutput("div -7/2 lit hi", 64'(hi), 64'hFFFF_FFFF);
`else
        checkOutput("div -7/2 lit lo", 64'(lo), 64'h7FFF_FFFC);
        checkOutput("div -7/2 lit hi", 64'(hi), 64'h0000_0001);
`endif
        applyStimulus("div overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus("div signed by zero", 2'b11, 32'hFFFF_FF00, 32'd0, 0);

        for (int i = 0; i < 50; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            applyStimulus($sformatf("rand%0d", i), ro, ra, rb, 0);
            if ($urandom_range(0, 3) == 0)
                writeHiLo(1'($urandom), 1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
